fpu_seq_ctrl: RTL
=================

# fpu_seq_ctrl

Operation sequencer for the double-precision FPU datapath. Accepts one operation request at a time over a valid/ready handshake and drives the shared `state`/`mode`/`operand` bus into the arithmetic cores and the value-correction stage. For SIN, COS and SQRT it runs the range-correction pre-pass, latches its outputs, then runs the iterative core for a fixed number of cycles. It returns the result with the correction side-information (exponent, quadrant) over a second valid/ready handshake.

## Interface

- `ARITH_LAT`, default 4: cycles the COMP/ADD/MUL/DIV cores hold `dp_state`; must be ≥1.
- `ITER_SINCOS`, default 16: CORDIC iterations for op 4/5; must be ≥1.
- `ITER_SQRT`, default 8: SQRT iterations; must be ≥1.
- `CNT_W`, default 5: iteration counter width; must satisfy 2^CNT_W ≥ max(N).
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: equals (FSM in IDLE && rst_n).
- `req_op` in 3: 0 COMP, 1 ADD, 2 MUL, 3 DIV, 4 SIN, 5 COS, 6 SQRT, 7 PASS.
- `req_operand` in 64: IEEE-754 double operand.
- `dp_state` out 4: datapath state code: 0 IDLE, 1 COMP, 2 ADD, 3 MUL, 4 DIV, 5 SIN_COS, 6 SQUARE_ROOT, 7 CORRECT_MODE.
- `dp_mode` out 3: latched op; 0 in IDLE.
- `dp_operand` out 64: operand to the datapath.
- `corr_result` in 64, `corr_exponent` in 11, `corr_quadrant` in 3: registered outputs of the correction stage.
- `iter_result` in 64: core result, valid during the last RUN cycle.
- `resp_valid` out 1, `resp_ready` in 1: response handshake.
- `resp_data` out 64, `resp_exponent` out 11, `resp_quadrant` out 3: response payload.
- `busy` out 1: FSM not IDLE.

## Operation

- FSM states: IDLE, CORR, CWAIT, RUN, DONE.
- **IDLE**
  - Drives `dp_state`=0, `dp_mode`=0, `dp_operand`=0.
  - On `req_valid && req_ready`: latch op and operand into `op_q`/`opnd_q`.
  - op 0–3 → RUN, count=ARITH_LAT−1. op 4–7 → CORR.
- **CORR** (1 cycle)
  - Drives `dp_state`=7, `dp_mode`=`op_q`, `dp_operand`=`opnd_q`. → CWAIT.
- **CWAIT** (1 cycle)
  - Drives `dp_state`=0, `dp_mode`=`op_q`.
  - The correction stage clears `corr_result` unless it sees state 7, so the controller captures it here:
    - `opnd_q`←`corr_result`.
    - `resp_exponent`←`corr_exponent` if op=6, else 0.
    - `resp_quadrant`←`corr_quadrant` if op∈{4,5}, else 0.
  - op 7 → DONE with `resp_data`←`corr_result`.
  - op 4/5 → RUN, count=ITER_SINCOS−1. op 6 → RUN, count=ITER_SQRT−1.
- **RUN**
  - Drives `dp_state` = op+1 for 0–3, 5 for 4/5, 6 for 6. `dp_mode`=`op_q`, `dp_operand`=`opnd_q` (constant for the whole RUN).
  - Count decrements each cycle. At count==0: `resp_data`←`iter_result` → DONE.
  - For op 0–3: `resp_exponent`=0, `resp_quadrant`=0.
- **DONE**
  - `resp_valid`=1, payload stable; `dp_state`=0.
  - On `resp_ready` → IDLE. Payload registers hold until the next capture.
- Reset (any state, including mid-RUN): FSM→IDLE, count=0, `op_q`/`opnd_q`=0, `resp_*`=0, `resp_valid`=0, `busy`=0. The in-flight operation is discarded with no response.
- `req_valid` outside IDLE is not accepted (`req_ready`=0). The requester must hold the request.

## Timing

- Accept edge = E0.
- op 0–3: `resp_valid` high after edge E0+ARITH_LAT.
- op 4/5/6: CORR is the cycle after E0; `resp_valid` after edge E0+2+N.
- op 7: `resp_valid` after edge E0+2.
- `resp_ready` high on the first DONE cycle → IDLE next edge. Next accept is possible at the following edge (one idle cycle minimum between ops).
- `req_ready` depends only on state and `rst_n`. It has no combinational path from `req_valid`.

## Configuration

- `FPU_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort` high in CORR, CWAIT, RUN or DONE → IDLE at the next edge, `resp_valid` low, no response, payload registers unchanged.
  - `abort` in IDLE is ignored; a simultaneous request is accepted.
- Undefined: port absent; operations always complete.

## Structure

- Shared package `fpu_pkg`: datapath state codes (IDLE…CORRECT_MODE), op codes 0–7, controller FSM enum.
- Sub-module `fpu_iter_cnt`: a CNT_W down-counter with load, decrement and `zero` outputs.

## Test plan

- ADD, ARITH_LAT=4, `resp_ready`=1 → `dp_state`=2 for exactly 4 cycles; `resp_valid` 4 cycles after accept; `resp_data`=`iter_result`.
- SQRT 16.0 (0x4030000000000000) → CORR cycle drives 7/6/0x4030…; RUN `dp_operand`=0x3FF0000000000000, `dp_state`=6 for 8 cycles; `resp_exponent`=2.
- SIN −1.0 (0xBFF0000000000000) → RUN `dp_operand`=0x3FF0000000000000 for 16 cycles; `resp_quadrant`=4.
- PASS 0x123456789ABCDEF0 with `resp_ready` low 5 cycles → `resp_valid` at E0+2, payload stable, `req_ready`=0 throughout, IDLE one edge after `resp_ready`.
- `rst_n` low in the 3rd RUN cycle of COS → next cycle all outputs 0, `req_ready`=0 while low, 1 after release, no response.
- `FPU_SEQ_ABORT_EN`: `abort` in DONE → `resp_valid` drops next edge; new MUL accepted the following cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operation sequencer: datapath state codes,
// operation codes and the controller FSM states.
package fpu_pkg;

  typedef enum logic [3:0] {
    DP_IDLE         = 4'd0,
    DP_COMP         = 4'd1,
    DP_ADD          = 4'd2,
    DP_MUL          = 4'd3,
    DP_DIV          = 4'd4,
    DP_SIN_COS      = 4'd5,
    DP_SQUARE_ROOT  = 4'd6,
    DP_CORRECT_MODE = 4'd7
  } dp_state_e;

  typedef enum logic [2:0] {
    OP_COMP = 3'd0,
    OP_ADD  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SIN  = 3'd4,
    OP_COS  = 3'd5,
    OP_SQRT = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORR,
    S_CWAIT,
    S_RUN,
    S_DONE
  } ctrl_state_e;

  // Ops that go through the range-correction pre-pass before (or instead of) a core run.
  function automatic logic needs_corr(input op_e op);
    return op inside {OP_SIN, OP_COS, OP_SQRT, OP_PASS};
  endfunction

  function automatic dp_state_e run_code(input op_e op);
    case (op)
      OP_COMP:        return DP_COMP;
      OP_ADD:         return DP_ADD;
      OP_MUL:         return DP_MUL;
      OP_DIV:         return DP_DIV;
      OP_SIN, OP_COS: return DP_SIN_COS;
      OP_SQRT:        return DP_SQUARE_ROOT;
      default:        return DP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fpu_iter_cnt.sv
// Iteration down-counter for the FPU sequencer: load, saturating decrement, zero flag.
module fpu_iter_cnt #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fpu_seq_ctrl.sv
// FPU operation sequencer: request handshake, correction pre-pass, timed core run, response handshake.
// Optional `FPU_SEQ_ABORT_EN adds an abort input that drops any in-flight operation.
module fpu_seq_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned ARITH_LAT   = 4,
  parameter int unsigned ITER_SINCOS = 16,
  parameter int unsigned ITER_SQRT   = 8,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [63:0] req_operand,
  output logic [3:0]  dp_state,
  output logic [2:0]  dp_mode,
  output logic [63:0] dp_operand,
  input  logic [63:0] corr_result,
  input  logic [10:0] corr_exponent,
  input  logic [2:0]  corr_quadrant,
  input  logic [63:0] iter_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [10:0] resp_exponent,
  output logic [2:0]  resp_quadrant,
`ifdef FPU_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy
);

  ctrl_state_e      state;
  op_e              op_q;
  logic [63:0]      opnd_q;
  logic             abort_now;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

`ifdef FPU_SEQ_ABORT_EN
  assign abort_now = abort && (state != S_IDLE);
`else
  assign abort_now = 1'b0;
`endif

  assign req_ready  = (state == S_IDLE) && rst_n;
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_DONE);

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (state == S_IDLE && req_valid && req_ready && !needs_corr(op_e'(req_op))) begin
      cnt_load     = 1'b1;
      cnt_load_val = CNT_W'(ARITH_LAT - 1);
    end else if (state == S_CWAIT && !abort_now) begin
      if (op_q == OP_SQRT) begin
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(ITER_SQRT - 1);
      end else if (op_q inside {OP_SIN, OP_COS}) begin
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(ITER_SINCOS - 1);
      end
    end
  end

  fpu_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (state == S_RUN),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= OP_COMP;
      opnd_q        <= '0;
      resp_data     <= '0;
      resp_exponent <= '0;
      resp_quadrant <= '0;
    end else if (abort_now) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= op_e'(req_op);
            opnd_q <= req_operand;
            state  <= needs_corr(op_e'(req_op)) ? S_CORR : S_RUN;
          end
        end
        S_CORR: state <= S_CWAIT;
        // The correction stage zeroes its outputs once state 7 is gone, so capture now.
        S_CWAIT: begin
          opnd_q        <= corr_result;
          resp_exponent <= (op_q == OP_SQRT) ? corr_exponent : '0;
          resp_quadrant <= (op_q inside {OP_SIN, OP_COS}) ? corr_quadrant : '0;
          if (op_q == OP_PASS) begin
            resp_data <= corr_result;
            state     <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_zero) begin
            resp_data <= iter_result;
            if (!needs_corr(op_q)) begin
              resp_exponent <= '0;
              resp_quadrant <= '0;
            end
            state <= S_DONE;
          end
        end
        S_DONE: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dp_state   = DP_IDLE;
    dp_mode    = op_q;
    dp_operand = opnd_q;
    case (state)
      S_IDLE: begin
        dp_mode    = '0;
        dp_operand = '0;
      end
      S_CORR:  dp_state = DP_CORRECT_MODE;
      S_RUN:   dp_state = run_code(op_q);
      default: ;
    endcase
  end

endmodule
